spi_slave_rx_mode3: RTL and testbench
=====================================

Name: spi_slave_rx_mode3

Overview:
SPI mode-3 (CPOL=1, CPHA=1) slave receiver, MSB first. It sits on the far end of the team's SPI master transmitter link.
- Oversamples CS_N/SCLK/MOSI in the In_clk domain.
- Samples MOSI on each synchronized SCLK rising edge.
- Presents each completed byte with a one-cycle valid strobe.
- Supports multi-byte frames while CS_N stays low, and flags frames aborted mid-byte.

Parameters:
DATA_W, 8, bits per word; shift register and counter width derive from it.
SYNC_STAGES, 2, flip-flop depth of input synchronizers (min 2).

Ports:
In_clk  input  1  system clock; must be >= 8x SCLK frequency.
In_rst_n  input  1  asynchronous, active-low reset.
In_spi_cs_n  input  1  chip select from master, active low, asynchronous to In_clk.
In_spi_sclk  input  1  SPI clock from master, idle high.
In_spi_mosi  input  1  serial data from master.
Out_rx_data  output  DATA_W  last completed word; holds until next completion.
Out_rx_valid  output  1  one-cycle pulse when Out_rx_data updates.
Out_rx_busy  output  1  high while a frame is active (state RECV).
Out_frame_err  output  1  one-cycle pulse when CS_N deasserts with a partial word.

Behaviour:
- Reset: clock domain In_clk; reset In_rst_n, asynchronous, active-low.
  - Sync chains reset to cs_n=1, sclk=1, mosi=0.
  - Out_rx_data=0, Out_rx_valid=0, Out_rx_busy=0, Out_frame_err=0.
  - bit_cnt=0, shift=0, state=IDLE.
- Synchronizers: all three inputs pass through SYNC_STAGES flops, with equal depth so MOSI stays aligned to SCLK. One extra register on synced sclk gives rise = sclk_s & ~sclk_d. One extra register on synced cs_n gives cs_fall and cs_rise.
- FSM, two states:
  - IDLE: on cs_fall, clear bit_cnt and shift, go to RECV. SCLK edges are ignored.
  - RECV:
    - On rise, shift <= {shift[DATA_W-2:0], mosi_s} and bit_cnt++.
    - When bit_cnt==DATA_W-1 and rise:
      - Out_rx_data <= {shift[DATA_W-2:0], mosi_s} on the next In_clk edge.
      - Out_rx_valid=1 for exactly that cycle.
      - bit_cnt wraps to 0 and the FSM stays in RECV for the next word.
    - On cs_rise, go to IDLE.
      - If bit_cnt!=0, Out_frame_err pulses one cycle; the partial word is discarded and Out_rx_data is unchanged.
      - If bit_cnt==0, the frame closes cleanly with no pulse.
- Simultaneous cs_rise and rise in the same cycle: cs_rise wins. That sample is discarded; if it would have completed a word, there is no valid and frame_err pulses.
- Falling SCLK edges are never used. Leading/trailing SCLK-high idle time around CS is tolerated.
- Latency: Out_rx_valid asserts SYNC_STAGES+2 In_clk cycles after the 8th SCLK rising edge at the pins.
- Out_rx_busy = (state==RECV), registered.
- Reset asserted mid-frame: immediate return to reset values. After release, the FSM stays in IDLE until a fresh cs_fall, so a CS that is already low is ignored until it deasserts and reasserts.
- No overrun detection: the consumer must take each word within one word time (DATA_W SCLK periods).

Decomposition:
- Shared package spi_pkg:
  - mode constants CPOL=1, CPHA=1;
  - state encoding IDLE/RECV;
  - DATA_W default;
  - minimum oversample ratio constant 8.
- One natural sub-module, spi_sync_edge: parameterized SYNC_STAGES synchronizer plus edge detector, instantiated for SCLK and CS_N. MOSI uses the synchronizer only.

Test Plan:
- Single word: REF 50 MHz, SCLK 50 kHz, CS low, send 0xA5, CS high -> exactly one Out_rx_valid pulse with Out_rx_data=0xA5. Out_rx_busy is high from CS low + SYNC_STAGES+2 cycles until CS high + SYNC_STAGES+2 cycles. No frame_err.
- Multi-word: one CS frame carrying 0x3C then 0xC3 -> two valid pulses 8 SCLK periods apart, data 0x3C then 0xC3, no frame_err.
- Abort: send the 5 MSBs of 0xFF after a prior 0x12, then CS high -> Out_frame_err pulses once, no valid, Out_rx_data stays 0x12, FSM in IDLE.
- Glitch immunity: toggle SCLK 16 times and MOSI randomly with CS held high -> no valid, no err, busy stays 0.
- Reset mid-frame: assert In_rst_n low after 4 bits of 0x81 -> all outputs 0. Release with CS still low -> nothing received. A new CS frame carrying 0x81 -> valid with 0x81.
- Boundary timing: SCLK at exactly In_clk/8, send 0x00, 0xFF, 0x55 back-to-back -> three valid pulses with correct data. Also CS rising in the same synced cycle as the 8th rise -> frame_err, no valid.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI link constants: bus mode, receiver state encoding and sizing helpers.
package spi_pkg;

    localparam int unsigned CPOL           = 1;
    localparam int unsigned CPHA           = 1;
    localparam int unsigned DATA_W_DEF     = 8;
    localparam int unsigned MIN_OVERSAMPLE = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Width of a counter that must hold 0 .. n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous level, with rise/fall detection
// against one extra register stage.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic In_clk,
    input  logic In_rst_n,
    input  logic din,
    output logic sync,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   dly;

    always_ff @(posedge In_clk or negedge In_rst_n) begin
        if (!In_rst_n) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            dly   <= RST_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            dly   <= chain[SYNC_STAGES-1];
        end
    end

    assign sync   = chain[SYNC_STAGES-1];
    assign rise_c = sync & ~dly;
    assign fall_c = ~sync & dly;

endmodule

// File: rtl/spi_slave_rx_mode3.sv
// SPI mode-3 slave receiver, MSB first, oversampled in the In_clk domain.
// Emits each completed word with a one-cycle valid and flags partial-word aborts.
module spi_slave_rx_mode3
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              In_clk,
    input  logic              In_rst_n,
    input  logic              In_spi_cs_n,
    input  logic              In_spi_sclk,
    input  logic              In_spi_mosi,
    output logic [DATA_W-1:0] Out_rx_data,
    output logic              Out_rx_valid,
    output logic              Out_rx_busy,
    output logic              Out_frame_err
);

    localparam int unsigned CNT_W          = cnt_width(DATA_W);
    localparam int unsigned SETTLE         = SYNC_STAGES + 1;
    localparam int unsigned SETTLE_W       = cnt_width(SETTLE + 1);
    localparam bit          SAMPLE_ON_RISE = (CPOL == CPHA);

    logic cs_s, cs_rise_c, cs_fall_c;
    logic sclk_level_unused, sclk_rise_c, sclk_fall_c;
    logic sample_c;
    logic mosi_s;
    logic [SYNC_STAGES-1:0] mosi_chain;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b1)
    ) u_sync_cs (
        .In_clk   (In_clk),
        .In_rst_n (In_rst_n),
        .din      (In_spi_cs_n),
        .sync     (cs_s),
        .rise_c   (cs_rise_c),
        .fall_c   (cs_fall_c)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'(CPOL))
    ) u_sync_sclk (
        .In_clk   (In_clk),
        .In_rst_n (In_rst_n),
        .din      (In_spi_sclk),
        .sync     (sclk_level_unused),
        .rise_c   (sclk_rise_c),
        .fall_c   (sclk_fall_c)
    );

    // MOSI gets the same depth as SCLK so data stays aligned to the sampling edge.
    always_ff @(posedge In_clk or negedge In_rst_n) begin
        if (!In_rst_n) begin
            mosi_chain <= '0;
        end else begin
            mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], In_spi_mosi};
        end
    end

    assign mosi_s   = mosi_chain[SYNC_STAGES-1];
    assign sample_c = SAMPLE_ON_RISE ? sclk_rise_c : sclk_fall_c;

    // A CS already low at reset release must not open a frame: arm only after
    // the sync chain has refilled and CS has been seen high.
    logic [SETTLE_W-1:0] settle_cnt;
    logic                cs_armed;

    always_ff @(posedge In_clk or negedge In_rst_n) begin
        if (!In_rst_n) begin
            settle_cnt <= '0;
            cs_armed   <= 1'b0;
        end else begin
            if (settle_cnt != SETTLE_W'(SETTLE)) begin
                settle_cnt <= settle_cnt + SETTLE_W'(1);
            end
            if ((settle_cnt == SETTLE_W'(SETTLE)) && cs_s) begin
                cs_armed <= 1'b1;
            end
        end
    end

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic [DATA_W-1:0]   shift, shift_nxt;
    logic [DATA_W-1:0]   rx_data_nxt;
    logic                rx_valid_nxt;
    logic                frame_err_nxt;

    always_ff @(posedge In_clk or negedge In_rst_n) begin
        if (!In_rst_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift         <= '0;
            Out_rx_data   <= '0;
            Out_rx_valid  <= 1'b0;
            Out_rx_busy   <= 1'b0;
            Out_frame_err <= 1'b0;
        end else begin
            state         <= state_nxt;
            bit_cnt       <= bit_cnt_nxt;
            shift         <= shift_nxt;
            Out_rx_data   <= rx_data_nxt;
            Out_rx_valid  <= rx_valid_nxt;
            Out_rx_busy   <= (state_nxt == RECV);
            Out_frame_err <= frame_err_nxt;
        end
    end

    // CS deassertion takes priority over a coincident sample edge.
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift;
        rx_data_nxt   = Out_rx_data;
        rx_valid_nxt  = 1'b0;
        frame_err_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (cs_fall_c && cs_armed) begin
                    bit_cnt_nxt = '0;
                    shift_nxt   = '0;
                    state_nxt   = RECV;
                end
            end
            RECV: begin
                if (cs_rise_c) begin
                    frame_err_nxt = (bit_cnt != '0);
                    bit_cnt_nxt   = '0;
                    state_nxt     = IDLE;
                end else if (sample_c) begin
                    shift_nxt = {shift[DATA_W-2:0], mosi_s};
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        bit_cnt_nxt  = '0;
                        rx_data_nxt  = {shift[DATA_W-2:0], mosi_s};
                        rx_valid_nxt = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_slave_rx_mode3.sv
// Self-checking bench for spi_slave_rx_mode3: drives mode-3 frames and compares
// against a word-level model of what the master sent.
module tb_spi_slave_rx_mode3;
    import spi_pkg::*;

    localparam int DW       = 8;
    localparam int SS       = 2;
    localparam int HALF_MIN = MIN_OVERSAMPLE / 2;

    logic          In_clk   = 1'b0;
    logic          In_rst_n = 1'b0;
    logic          cs_n     = 1'b1;
    logic          sclk     = 1'b1;
    logic          mosi     = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid, rx_busy, frame_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int err_cnt  = 0;
    int busy_cnt = 0;
    int last_rise_cyc = 0;
    logic [7:0] got_q[$];
    int         got_cyc[$];
    logic [7:0] model_data = 8'h00;

    spi_slave_rx_mode3 #(
        .DATA_W      (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .In_clk        (In_clk),
        .In_rst_n      (In_rst_n),
        .In_spi_cs_n   (cs_n),
        .In_spi_sclk   (sclk),
        .In_spi_mosi   (mosi),
        .Out_rx_data   (rx_data),
        .Out_rx_valid  (rx_valid),
        .Out_rx_busy   (rx_busy),
        .Out_frame_err (frame_err)
    );

    always #10 In_clk = ~In_clk;

    always @(posedge In_clk) cyc <= cyc + 1;

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge In_clk) begin
        if (rx_valid === 1'b1) begin
            got_q.push_back(rx_data);
            got_cyc.push_back(cyc);
        end
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
        if (rx_busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    task automatic cyc_wait(input int n);
        repeat (n) @(negedge In_clk);
    endtask

    // One CS frame of nbits MSB-first bits; simul raises CS on the last SCLK rise.
    task automatic run_frame(input string name, input logic [31:0] data,
                             input int nbits, input int half, input bit simul);
        int gb, eb, eff, nw, ngot, exp_err;
        logic [7:0] exp_w;
        gb  = got_q.size();
        eb  = err_cnt;
        eff = simul ? nbits - 1 : nbits;
        nw  = eff / 8;
        exp_err = (eff % 8 != 0) ? 1 : 0;

        @(negedge In_clk);
        cs_n = 1'b0;
        cyc_wait(half);
        total++;
        if (rx_busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_mid: got %b want 1", name, rx_busy);
        end
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = data[nbits-1-i];
            cyc_wait(half);
            if (simul && i == nbits - 1) cs_n = 1'b1;
            sclk = 1'b1;
            last_rise_cyc = cyc;
            cyc_wait(half);
        end
        if (!simul) cs_n = 1'b1;
        cyc_wait(SS + 8);

        ngot = got_q.size() - gb;
        total++;
        if (ngot != nw) begin
            bad++;
            $display("FAIL %s valid_count: got %0d want %0d", name, ngot, nw);
        end
        for (int k = 0; k < nw && k < ngot; k++) begin
            exp_w = 8'(data >> (nbits - 8 * (k + 1)));
            total++;
            if (got_q[gb+k] !== exp_w) begin
                bad++;
                $display("FAIL %s word%0d: got %h want %h", name, k, got_q[gb+k], exp_w);
            end
        end
        if (nw > 0) model_data = 8'(data >> (nbits - 8 * nw));
        total++;
        if (err_cnt - eb != exp_err) begin
            bad++;
            $display("FAIL %s frame_err_count: got %0d want %0d", name, err_cnt - eb, exp_err);
        end
        total++;
        if (rx_data !== model_data) begin
            bad++;
            $display("FAIL %s rx_data_hold: got %h want %h", name, rx_data, model_data);
        end
        total++;
        if (rx_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_end: got %b want 0", name, rx_busy);
        end
    endtask

    task automatic test_reset();
        In_rst_n = 1'b0;
        cyc_wait(3);
        total++;
        if ({rx_data, rx_valid, rx_busy, frame_err} !== 11'b0) begin
            bad++;
            $display("FAIL reset_outputs: got data=%h v=%b b=%b e=%b want all 0",
                     rx_data, rx_valid, rx_busy, frame_err);
        end
        In_rst_n = 1'b1;
        cyc_wait(10);
        total++;
        if (rx_busy !== 1'b0 || got_q.size() != 0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b valids=%0d want 0/0", rx_busy, got_q.size());
        end
    endtask

    task automatic test_single_word();
        int lat;
        run_frame("single", 32'hA5, 8, 500, 1'b0);
        lat = got_cyc[got_cyc.size()-1] - last_rise_cyc;
        total++;
        if (lat < SS + 1 || lat > SS + 2) begin
            bad++;
            $display("FAIL single_latency: got %0d want %0d..%0d", lat, SS + 1, SS + 2);
        end
    endtask

    task automatic test_multi_word();
        int n, gap;
        run_frame("multi", 32'h3CC3, 16, 6, 1'b0);
        n = got_cyc.size();
        gap = (n >= 2) ? got_cyc[n-1] - got_cyc[n-2] : -1;
        total++;
        if (gap != 16 * 6) begin
            bad++;
            $display("FAIL multi_spacing: got %0d want %0d", gap, 16 * 6);
        end
    endtask

    task automatic test_abort();
        run_frame("abort_pre", 32'h12, 8, 6, 1'b0);
        run_frame("abort", 32'h1F, 5, 6, 1'b0);
    endtask

    task automatic test_glitch();
        int gb, eb, bb;
        gb = got_q.size();
        eb = err_cnt;
        bb = busy_cnt;
        cs_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge In_clk);
            sclk = 1'b0;
            mosi = 1'($urandom);
            cyc_wait(HALF_MIN);
            sclk = 1'b1;
            cyc_wait(HALF_MIN);
        end
        cyc_wait(SS + 8);
        total++;
        if (got_q.size() != gb || err_cnt != eb || busy_cnt != bb) begin
            bad++;
            $display("FAIL glitch: got valids=%0d errs=%0d busy_cycles=%0d want 0/0/0",
                     got_q.size() - gb, err_cnt - eb, busy_cnt - bb);
        end
    endtask

    task automatic test_reset_mid_frame();
        int gb, eb;
        logic [7:0] w;
        w = 8'h81;
        @(negedge In_clk);
        cs_n = 1'b0;
        cyc_wait(6);
        for (int i = 0; i < 4; i++) begin
            sclk = 1'b0; mosi = w[7-i]; cyc_wait(6);
            sclk = 1'b1; cyc_wait(6);
        end
        In_rst_n = 1'b0;
        #1;
        model_data = 8'h00;
        total++;
        if ({rx_data, rx_valid, rx_busy, frame_err} !== 11'b0) begin
            bad++;
            $display("FAIL rstmid_outputs: got data=%h v=%b b=%b e=%b want all 0",
                     rx_data, rx_valid, rx_busy, frame_err);
        end
        cyc_wait(3);
        In_rst_n = 1'b1;
        gb = got_q.size();
        eb = err_cnt;
        for (int i = 0; i < 12; i++) begin
            sclk = 1'b0; mosi = (i < 4) ? w[3-i] : 1'($urandom); cyc_wait(6);
            sclk = 1'b1; cyc_wait(6);
        end
        total++;
        if (rx_busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_busy_cs_low: got %b want 0", rx_busy);
        end
        cs_n = 1'b1;
        cyc_wait(SS + 8);
        total++;
        if (got_q.size() != gb || err_cnt != eb || rx_data !== 8'h00) begin
            bad++;
            $display("FAIL rstmid_ignored: got valids=%0d errs=%0d data=%h want 0/0/00",
                     got_q.size() - gb, err_cnt - eb, rx_data);
        end
        run_frame("rstmid_fresh", 32'h81, 8, 6, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_min_ratio", 32'h00FF55, 24, HALF_MIN, 1'b0);
        run_frame("cs_with_8th_rise", 32'hA7, 8, HALF_MIN, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] d;
        int nb, hf;
        bit sm;
        for (int r = 0; r < 20; r++) begin
            d  = $urandom;
            nb = $urandom_range(1, 24);
            hf = $urandom_range(HALF_MIN, 8);
            sm = ($urandom_range(0, 3) == 0);
            run_frame($sformatf("rand%0d", r), d, nb, hf, sm);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_multi_word();
        test_abort();
        test_glitch();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
